// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE -> ACCESS -> RESP sequence per transaction,
// round-robin or fixed-priority selection between the CPU port (0) and loader port (1).
module mem_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              M_CS,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              BUSY,
  output logic              GNT
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate on sampled requests
  // ACCESS | memory strobed with the latched request
  // RESP   | ACK pulse to the granted port, requests ignored
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   last_gnt;
  logic   win;

  always_comb begin
    win = 1'b0;
    if (REQ0 && REQ1)
      win = (ROUND_ROBIN != 0) ? ~last_gnt : 1'b0;
    else if (REQ1)
      win = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      GNT      <= 1'b0;
      M_CS     <= 1'b0;
      M_WE     <= 1'b0;
      M_ADDR   <= '0;
      M_WDATA  <= '0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      RDATA0   <= '0;
      RDATA1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ACK0 <= 1'b0;
          ACK1 <= 1'b0;
          if (REQ0 || REQ1) begin
            GNT      <= win;
            last_gnt <= win;
            M_CS     <= 1'b1;
            M_WE     <= win ? WE1 : WE0;
            M_ADDR   <= win ? ADDR1 : ADDR0;
            M_WDATA  <= win ? WDATA1 : WDATA0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // M_RDATA settles in the second half of this cycle, so capture on its closing edge
          if (!M_WE) begin
            if (GNT) RDATA1 <= M_RDATA;
            else     RDATA0 <= M_RDATA;
          end
          M_CS    <= 1'b0;
          M_WE    <= 1'b0;
          M_ADDR  <= '0;
          M_WDATA <= '0;
          ACK0    <= ~GNT;
          ACK1    <= GNT;
          state   <= RESP;
        end
        RESP: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances on shared stimulus,
// checked against a cycle-number transaction model plus directed vector table.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST = 1'b1, REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [6:0]  ADDR0 = '0, ADDR1 = '0;
  logic [31:0] WDATA0 = '0, WDATA1 = '0;

  logic [1:0]  ack0_o, ack1_o, m_cs_o, m_we_o, busy_o, gnt_o;
  logic [6:0]  m_addr_o [2];
  logic [31:0] m_wdata_o [2];
  logic [31:0] m_rdata_i [2];
  logic [31:0] rdata0_o [2];
  logic [31:0] rdata1_o [2];

  mem_arbiter #(.ADDR_W(7), .DATA_W(32), .ROUND_ROBIN(1)) dut_rr (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .RDATA0(rdata0_o[0]), .RDATA1(rdata1_o[0]), .ACK0(ack0_o[0]), .ACK1(ack1_o[0]),
    .M_CS(m_cs_o[0]), .M_WE(m_we_o[0]), .M_ADDR(m_addr_o[0]), .M_WDATA(m_wdata_o[0]),
    .M_RDATA(m_rdata_i[0]), .BUSY(busy_o[0]), .GNT(gnt_o[0]));

  mem_arbiter #(.ADDR_W(7), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .RDATA0(rdata0_o[1]), .RDATA1(rdata1_o[1]), .ACK0(ack0_o[1]), .ACK1(ack1_o[1]),
    .M_CS(m_cs_o[1]), .M_WE(m_we_o[1]), .M_ADDR(m_addr_o[1]), .M_WDATA(m_wdata_o[1]),
    .M_RDATA(m_rdata_i[1]), .BUSY(busy_o[1]), .GNT(gnt_o[1]));

  function automatic logic [31:0] rom(input logic [6:0] a);
    if (a == 7'd5) return 32'h1234ABCD;
    return (32'h9E3779B9 * ({25'd0, a} + 32'd1)) ^ 32'h0BAD0000;
  endfunction

  // memory answers only during a read access; junk otherwise
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (m_cs_o[d] && !m_we_o[d]) m_rdata_i[d] <= rom(m_addr_o[d]);
      else                         m_rdata_i[d] <= $urandom;
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // reference: a transaction granted at edge t strobes memory in cycle t, acks in t+1,
  // and the next grant can happen no earlier than edge t+3
  bit          md_active [2];
  int          md_tg [2];
  int          md_free [2];
  bit          md_win [2], md_we [2], md_last [2], md_gnt [2];
  logic [6:0]  md_addr [2];
  logic [31:0] md_wd [2];
  logic [31:0] md_rd [2][2];

  task automatic model_edge(input int c);
    bit w;
    for (int d = 0; d < 2; d++) begin
      if (RST) begin
        md_active[d] = 0; md_last[d] = 1; md_gnt[d] = 0;
        md_rd[d][0] = '0; md_rd[d][1] = '0; md_free[d] = c + 1;
      end else begin
        if (md_active[d] && c == md_tg[d] + 1 && !md_we[d])
          md_rd[d][md_win[d]] = rom(md_addr[d]);
        if (c >= md_free[d] && (REQ0 || REQ1)) begin
          if (REQ0 && REQ1) w = (d == 0) ? !md_last[d] : 1'b0;
          else              w = REQ1;
          md_win[d] = w; md_last[d] = w; md_gnt[d] = w;
          md_we[d] = w ? WE1 : WE0;
          md_addr[d] = w ? ADDR1 : ADDR0;
          md_wd[d] = w ? WDATA1 : WDATA0;
          md_active[d] = 1; md_tg[d] = c; md_free[d] = c + 3;
        end
      end
    end
  endtask

  task automatic check_model();
    bit acc, rsp;
    string p;
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? "rr" : "fp";
      acc = md_active[d] && cyc == md_tg[d];
      rsp = md_active[d] && cyc == md_tg[d] + 1;
      chk({p, ".M_CS"}, 32'(m_cs_o[d]), 32'(acc));
      chk({p, ".M_WE"}, 32'(m_we_o[d]), 32'(acc && md_we[d]));
      chk({p, ".M_ADDR"}, 32'(m_addr_o[d]), acc ? 32'(md_addr[d]) : 32'd0);
      chk({p, ".M_WDATA"}, m_wdata_o[d], acc ? md_wd[d] : 32'd0);
      chk({p, ".ACK0"}, 32'(ack0_o[d]), 32'(rsp && !md_win[d]));
      chk({p, ".ACK1"}, 32'(ack1_o[d]), 32'(rsp && md_win[d]));
      chk({p, ".BUSY"}, 32'(busy_o[d]), 32'(acc || rsp));
      chk({p, ".GNT"}, 32'(gnt_o[d]), 32'(md_gnt[d]));
      chk({p, ".RDATA0"}, rdata0_o[d], md_rd[d][0]);
      chk({p, ".RDATA1"}, rdata1_o[d], md_rd[d][1]);
    end
  endtask

  task automatic cycle();
    model_edge(cyc + 1);
    @(posedge CLK);
    cyc++;
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, r0, r1, w0, w1;
    logic [6:0] a0, a1;
    logic [31:0] d0, d1;
    bit e_cs, e_ack0, e_ack1, e_gnt, e_busy, e_fgnt;
  } vec_t;
  vec_t vecs [$];

  task automatic add(input bit rst, r0, r1, w0, w1, input logic [6:0] a0, a1,
                     input logic [31:0] d0, d1, input bit cs, k0, k1, g, b, fg);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.e_cs = cs; v.e_ack0 = k0; v.e_ack1 = k1; v.e_gnt = g;
    v.e_busy = b; v.e_fgnt = fg;
    vecs.push_back(v);
  endtask

  initial begin
    //  rst r0 r1 w0 w1 a0 a1 d0 d1                 cs k0 k1 g b fg
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 5, 0, 0, 0,                  1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 5, 0, 0, 0,                  0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 7'h7F, 0, 32'hDEADBEEF,   1, 0, 0, 1, 1, 1);
    add(0, 0, 1, 0, 1, 0, 7'h7F, 0, 32'hDEADBEEF,   0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 1, 0, 0, 10, 20, 0, 0,              1, 0, 0, i[0], 1, 0);
      add(0, 1, 1, 0, 0, 10, 20, 0, 0,              0, !i[0], i[0], i[0], 1, 0);
      add(0, 1, 1, 0, 0, 10, 20, 0, 0,              0, 0, 0, i[0], 0, 0);
    end
    add(0, 0, 1, 0, 0, 0, 30, 0, 0,                 1, 0, 0, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 30, 0, 0,                 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 0, 1);

    @(posedge CLK); #1;
    foreach (vecs[i]) begin
      RST = vecs[i].rst; REQ0 = vecs[i].r0; REQ1 = vecs[i].r1;
      WE0 = vecs[i].w0; WE1 = vecs[i].w1; ADDR0 = vecs[i].a0; ADDR1 = vecs[i].a1;
      WDATA0 = vecs[i].d0; WDATA1 = vecs[i].d1;
      cycle();
      chk($sformatf("vec%0d.cs", i), 32'(m_cs_o[0]), 32'(vecs[i].e_cs));
      chk($sformatf("vec%0d.ack0", i), 32'(ack0_o[0]), 32'(vecs[i].e_ack0));
      chk($sformatf("vec%0d.ack1", i), 32'(ack1_o[0]), 32'(vecs[i].e_ack1));
      chk($sformatf("vec%0d.gnt", i), 32'(gnt_o[0]), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d.busy", i), 32'(busy_o[0]), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.fp_gnt", i), 32'(gnt_o[1]), 32'(vecs[i].e_fgnt));
      if (i == 2) chk("single_read.rdata0", rdata0_o[0], 32'h1234ABCD);
      if (i == 4) chk("single_write.mwdata", m_wdata_o[0], 32'hDEADBEEF);
      if (i == 5) chk("single_write.rdata1", rdata1_o[0], 32'd0);
    end

    // reset landing in the ACCESS cycle of a read
    REQ0 = 1; WE0 = 0; ADDR0 = 7'd5; cycle();
    chk("rst_mid.access_cs", 32'(m_cs_o[0]), 32'd1);
    RST = 1; cycle();
    RST = 0; REQ0 = 0;
    chk("rst_mid.cs", 32'(m_cs_o[0]), 32'd0);
    chk("rst_mid.ack0", 32'(ack0_o[0]), 32'd0);
    chk("rst_mid.rdata0", rdata0_o[0], 32'd0);
    chk("rst_mid.busy", 32'(busy_o[0]), 32'd0);
    cycle();
    chk("rst_mid.no_late_ack", 32'(ack0_o[0]), 32'd0);
    REQ0 = 1; ADDR0 = 7'd9; cycle();
    chk("after_rst.cs", 32'(m_cs_o[0]), 32'd1);
    cycle();
    REQ0 = 0;
    chk("after_rst.ack0", 32'(ack0_o[0]), 32'd1);
    chk("after_rst.rdata0", rdata0_o[0], rom(7'd9));
    cycle();

    // address changes after grant must not leak into the transaction
    REQ0 = 1; ADDR0 = 7'd3; cycle();
    ADDR0 = 7'd9;
    chk("held.m_addr", 32'(m_addr_o[0]), 32'd3);
    cycle();
    REQ0 = 0;
    chk("held.rdata0", rdata0_o[0], rom(7'd3));
    cycle();

    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 59) == 0);
      REQ0 = ($urandom_range(0, 99) < 60);
      REQ1 = ($urandom_range(0, 99) < 60);
      WE0 = $urandom_range(0, 1); WE1 = $urandom_range(0, 1);
      ADDR0 = 7'($urandom); ADDR1 = 7'($urandom);
      WDATA0 = $urandom; WDATA1 = $urandom;
      cycle();
      n_cmp++;
      if (ack0_o[0] && ack1_o[0]) begin
        n_bad++;
        $display("FAIL dual_ack @cycle %0d: got both ACKs high, required at most one", cyc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
